mult4_slice_sched: RTL
======================

Name: mult4_slice_sched

Overview:
- Multi-cycle sequencer that computes a DW x DW unsigned product through one shared SW x SW slice multiplier. In the 4-bit configuration this is a single 2x2 core instead of four.
- The core itself (any of the team's trained 2-bit multipliers) lives outside this block. The block drives the core's A/B inputs, samples its P output, and shift-accumulates the partial products.
- Sits between an operand producer and a result consumer. Uses valid/ready handshakes on both sides.

Parameters:
- DW, 4, operand width; must be a multiple of SW.
- SW, 2, slice width of the shared core.
- NS, DW/SW, slices per operand (derived localparam, not overridable). Partial-product count is NS*NS = 4.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair A/B valid.
- in_ready  out  1  block can accept operands.
- A  in  DW  multiplicand, unsigned.
- B  in  DW  multiplier, unsigned.
- core_A  out  SW  slice of captured A driven to the shared core.
- core_B  out  SW  slice of captured B driven to the shared core.
- core_P  in  2*SW  combinational product returned by the core.
- out_valid  out  1  P holds a final product.
- out_ready  in  1  consumer accepts P.
- P  out  2*DW  product.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, P=0.
  - Operand and accumulator registers cleared; slice indices i=j=0.
  - core_A and core_B read 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture A and B into a_q/b_q, clear the accumulator, set i=0 and j=0, go to RUN.
- RUN:
  - in_ready=0.
  - core_A = a_q[i*SW +: SW], core_B = b_q[j*SW +: SW]; both decoded combinationally from registered a_q/b_q/i/j.
  - Each cycle: acc <= acc + (core_P zero-extended to 2*DW) << ((i+j)*SW).
  - Issue order: j is the inner index, i the outer, giving (0,0),(0,1),(1,0),(1,1) for NS=2. This matches ll, lh, hl, hh.
  - Index update: j <= j+1; when j=NS-1, j wraps to 0 and i <= i+1.
  - The cycle that accumulates (NS-1,NS-1) goes to DONE and loads P with the final sum.
- DONE:
  - out_valid=1; P stable; in_ready=0.
  - On out_ready: go to IDLE and drop out_valid next cycle.
  - P holds its last value in IDLE; it is not cleared.
- Latency: accept at edge 0, RUN for NS*NS cycles, out_valid high after edge NS*NS. That is 4 cycles for DW=4.
- Throughput: one product per NS*NS+2 cycles with out_ready tied high.
  - No accept in the DONE->IDLE cycle; in_ready rises only once IDLE is entered.
- Arithmetic and widths:
  - Accumulator is 2*DW bits. The max sum (2^DW-1)^2 fits, so there is no overflow path.
  - Shift amounts are computed at 2*DW width.
- Boundary conditions:
  - in_valid while not IDLE: ignored; in_ready=0 is the backpressure.
  - A and B are not sampled after the capture edge; changes during RUN have no effect.
  - out_ready asserted with out_valid=0: ignored.
  - out_ready held low: DONE holds indefinitely with P and out_valid stable.
  - Reset mid-RUN or in DONE: all registers return to reset values on the next edge; the in-flight product is discarded and no out_valid is produced.
  - Operand 0: still takes the full NS*NS cycles; there is no early termination.
- core_P is assumed combinational from core_A/core_B within one cycle. No core latency is supported.

Decomposition:
- Shared package: state enum (IDLE, RUN, DONE), default DW/SW constants, and a slice-shift helper function ((i+j)*SW).
- Natural sub-module: mult4_slice_acc, holding the accumulator register and the shift-add datapath. It has load-clear and add-enable controls driven by the FSM.
- The shared 2x2 core is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then A=4'hF, B=4'hF, out_ready=1:
  - core_A/core_B sequence (3,3),(3,3),(3,3),(3,3).
  - out_valid high exactly 4 cycles after accept with P=8'hE1, then back to IDLE.
- A=4'hA, B=4'h6:
  - core sequence (2,2),(2,1),(2,2),(2,1).
  - P=8'h3C.
- Backpressure: A=4'h7, B=4'h9, out_ready=0 for 5 cycles:
  - P=8'h3F and out_valid held stable throughout.
  - in_valid pulses during that time are ignored (in_ready=0).
  - Release out_ready -> IDLE.
- A=0, B=4'hD:
  - Full 4-cycle RUN, P=8'h00.
  - Back-to-back second op A=4'h3, B=4'h5 gives P=8'h0F. Its accept occurs no earlier than 2 cycles after the first out_valid rises.
- Drive rst_n=0 during the 2nd RUN cycle of A=4'hF, B=4'h2:
  - Next edge: state IDLE, out_valid=0, P=0, in_ready=1.
  - No result is ever presented for that operation.
- Random: 1000 operand pairs with random out_ready. Scoreboard checks P == A*B and that each result is delivered exactly once.

Source files
------------

// File: rtl/mult4_slice_sched_pkg.sv
// Shared state type, default widths and slice-shift helper for the
// slice-multiplier sequencer.
package mult4_slice_sched_pkg;

    localparam int DEF_DW = 4;
    localparam int DEF_SW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit position of the partial product for slice pair (i, j).
    function automatic int slice_shift(input int i, input int j, input int sw);
        return (i + j) * sw;
    endfunction

endpackage

// File: rtl/mult4_slice_acc.sv
// Shift-add accumulator: adds one zero-extended core product, shifted into
// place, per enabled cycle.
module mult4_slice_acc
    import mult4_slice_sched_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int SW = DEF_SW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            add_en,
    input  logic [2*SW-1:0] core_p,
    input  logic [2*DW-1:0] shamt,
    output logic [2*DW-1:0] sum
);

    logic [2*DW-1:0] acc_q;
    logic [2*DW-1:0] term;

    assign term = (2*DW)'(core_p) << shamt;
    assign sum  = acc_q + term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (add_en) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/mult4_slice_sched.sv
// Sequences a DW x DW unsigned multiply through one external SW x SW core,
// one partial product per cycle, with valid/ready on both sides.
module mult4_slice_sched
    import mult4_slice_sched_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int SW = DEF_SW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   A,
    input  logic [DW-1:0]   B,
    output logic [SW-1:0]   core_A,
    output logic [SW-1:0]   core_B,
    input  logic [2*SW-1:0] core_P,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] P,
    output logic            busy
);

    localparam int NS = DW / SW;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    state_t          state_q, state_d;
    logic [DW-1:0]   a_q, b_q;
    logic [IW-1:0]   i_q, j_q;
    logic [2*DW-1:0] p_q;
    logic [2*DW-1:0] shamt;
    logic [2*DW-1:0] sum;
    logic            acc_clear, acc_add;
    logic            last_slice;

    assign last_slice = (i_q == IW'(NS - 1)) && (j_q == IW'(NS - 1));
    assign shamt      = (2*DW)'(slice_shift(int'(i_q), int'(j_q), SW));

    // Slices are only presented while running so the core sees zeros otherwise.
    assign core_A = (state_q == RUN) ? a_q[i_q*SW +: SW] : '0;
    assign core_B = (state_q == RUN) ? b_q[j_q*SW +: SW] : '0;
    assign P      = p_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d   = RUN;
                    acc_clear = 1'b1;
                end
            end
            RUN: begin
                busy    = 1'b1;
                acc_add = 1'b1;
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // j is the inner index; the final slice pair also latches the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            i_q <= '0;
            j_q <= '0;
            p_q <= '0;
        end else if (state_q == IDLE && in_valid) begin
            a_q <= A;
            b_q <= B;
            i_q <= '0;
            j_q <= '0;
        end else if (state_q == RUN) begin
            if (j_q == IW'(NS - 1)) begin
                j_q <= '0;
                i_q <= i_q + 1'b1;
            end else begin
                j_q <= j_q + 1'b1;
            end
            if (last_slice) begin
                p_q <= sum;
            end
        end
    end

    mult4_slice_acc #(
        .DW(DW),
        .SW(SW)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (acc_clear),
        .add_en (acc_add),
        .core_p (core_P),
        .shamt  (shamt),
        .sum    (sum)
    );

endmodule
